mvm_uart_rx: RTL
================

Name: mvm_uart_rx

Overview:
- UART receive front end of the matrix-vector-multiply UART system. Sits between the serial `rx` pin and the word packer that assembles matrix/vector operands for the MVM core.
- Synchronises the asynchronous line, detects and validates start bits, and samples each bit at mid-period.
- Delivers each received word through a one-entry valid/ready output buffer, with single-cycle framing-error and overrun flags.

Parameters:
- CLOCKS_PER_PULSE, 4, clock cycles per UART bit period; must be ≥ 2.
- BITS_PER_WORD, 8, data bits per frame, sent LSB first; no parity, one stop bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- m_data  output  BITS_PER_WORD  received word.
- m_valid  output  1  m_data holds an unconsumed word.
- m_ready  input  1  downstream accepts the word this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.

Behaviour:
- Reset (synchronous, active-high):
  - m_valid=0, m_data=0, frame_err=0, overrun=0.
  - Both synchroniser flops = 1; counters = 0; state = BREAK.
  - A frame in progress when reset is asserted is abandoned.
- Synchroniser: rx passes through 2 flops. All FSM decisions use the synced bit `rxs`, which adds 2 cycles of latency.
- Counters:
  - `cnt` is a bit-period counter, width $clog2(CLOCKS_PER_PULSE), cleared on every state change.
  - `idx` is the data-bit index, width $clog2(BITS_PER_WORD+1).
- FSM states:
  - IDLE: if rxs==0, go to START (cnt=0).
  - START: when cnt==CLOCKS_PER_PULSE/2-1 (integer divide), sample rxs. If rxs==1, the low was a glitch: go to IDLE, nothing emitted. If rxs==0, go to DATA with idx=0.
  - DATA: when cnt==CLOCKS_PER_PULSE-1, shift rxs into the MSB of the shift register (LSB-first assembly) and increment idx. After the BITS_PER_WORD-th sample, go to STOP.
  - STOP: when cnt==CLOCKS_PER_PULSE-1, sample rxs.
    - rxs==1: the word completes; go to IDLE.
    - rxs==0: pulse frame_err on the next cycle, drop the word, go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. This prevents a held-low line from re-triggering a start.
- Output buffer:
  - On word completion: if m_valid==0, or m_valid && m_ready in the same cycle, load m_data and set m_valid=1 on the next cycle.
  - Otherwise pulse overrun on the next cycle, discard the new word, and keep m_data unchanged.
  - m_valid && m_ready with no new word: m_valid clears on the next cycle; m_data holds its last value.
  - m_data is stable whenever m_valid && !m_ready.
- Latency: m_valid rises exactly 1 cycle after the stop-bit sample. That is at most (BITS_PER_WORD+1)*CLOCKS_PER_PULSE + CLOCKS_PER_PULSE/2 + 4 cycles after the falling edge of rx at the pin (≤ 42 cycles with defaults).
- Flags: frame_err and overrun are never asserted together, and each lasts exactly 1 cycle.
- No combinational path from rx or m_ready to any output. All outputs are registered.

Decomposition:
- Shared package `mvm_uart_pkg`:
  - RX state enum: IDLE, START, DATA, STOP, BREAK.
  - Default CLOCKS_PER_PULSE and BITS_PER_WORD localparams, shared with the transmitter and top level.
- One sub-module: `sync_2ff`, a 2-flop synchroniser with a parameterised reset value (1 here). It is reusable for other async inputs.

Test Plan:
1. Reset, then rx=1 for 30 cycles -> m_valid, frame_err and overrun all stay 0.
2. Frame 0xA5 at 4 clk/bit, m_ready=1 -> exactly one m_valid cycle with m_data=0xA5, within 42 cycles of the rx falling edge.
3. Back-to-back frames 0x3C then 0xFF with m_ready=0 -> m_valid held with m_data=0x3C, one overrun pulse at the end of the second frame. Then raise m_ready=1 for 1 cycle -> m_valid drops, and 0xFF is never presented.
4. Buffer holds 0x11 and m_ready=1 in the same cycle that 0x22 completes -> no overrun, next cycle m_data=0x22 with m_valid=1.
5. Frame 0x55 with stop bit 0, rx then held low 12 cycles -> one frame_err pulse, no m_valid, no spurious start during the low period. rx then high ≥4 cycles and frame 0x12 sent -> m_data=0x12.
6. Single-cycle rx low glitch -> no m_valid and no flags. Separately, rst pulsed for 1 cycle mid-frame at data bit 4 -> all outputs 0 on the next cycle; a clean frame 0x81 after ≥1 idle bit period -> m_data=0x81.

Source files
------------

// File: rtl/mvm_uart_pkg.sv
// ---------------------------------------------------------------------------
// mvm_uart_pkg
// Shared definitions for the MVM UART slice (receiver, transmitter, top).
//   DEF_CLOCKS_PER_PULSE : default clock cycles per UART bit period
//   DEF_BITS_PER_WORD    : default data bits per frame (LSB first, 8N1 style)
//   rx_state_e           : receiver FSM states
// ---------------------------------------------------------------------------
package mvm_uart_pkg;

  localparam int DEF_CLOCKS_PER_PULSE = 4;
  localparam int DEF_BITS_PER_WORD    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous inputs, with a parameterised reset
// value so idle-high lines do not look active while coming out of reset.
//   clk  : destination clock
//   rst  : synchronous, active-high reset (both flops load RESET_VAL)
//   d    : asynchronous input
//   q    : synchronised output, two cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mvm_uart_rx.sv
// ---------------------------------------------------------------------------
// mvm_uart_rx
// UART receive front end: synchronises rx, validates start bits at half a
// bit period, samples data mid-bit, checks the stop bit and hands each word
// to the packer through a one-entry valid/ready buffer.
//   clk       : system clock
//   rst       : synchronous, active-high reset; abandons any frame in flight
//   rx        : asynchronous serial line, idles high
//   m_data    : received word
//   m_valid   : m_data holds an unconsumed word
//   m_ready   : downstream accepts the word this cycle
//   frame_err : one-cycle pulse, stop bit sampled low (word dropped)
//   overrun   : one-cycle pulse, completed word dropped, buffer was full
// ---------------------------------------------------------------------------
module mvm_uart_rx
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam int IDX_W = $clog2(BITS_PER_WORD + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_WORD - 1);

  logic                     rxs;
  rx_state_e                state;
  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         idx;
  logic [BITS_PER_WORD-1:0] shreg;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BREAK;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: these defaults are non-blocking; a later assignment in the same
      // block overrides them, which is how one-cycle pulses and the
      // consume/reload race on m_valid resolve without extra logic.
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= START;
          end
        end

        // Re-check the line half a bit in; a high here means a glitch.
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Sampling point is now mid-bit; shift in at the MSB so the first
        // (LSB) bit ends up at bit 0 after BITS_PER_WORD samples.
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[BITS_PER_WORD-1:1]};
            idx   <= idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              // A word being consumed this cycle frees the slot for the new one.
              if (!m_valid || m_ready) begin
                m_data  <= shreg;
                m_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Wait for the line to return high so a held-low line (break
        // condition) cannot masquerade as a stream of start bits.
        BREAK: begin
          cnt <= '0;
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= BREAK;
        end
      endcase
    end
  end

endmodule
